// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared state encoding and default widths for the counter sequencer
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } cnt_ctrl_state_e;

  localparam int CNT_WIDTH  = 4;
  localparam int CNT_TWIDTH = 8;

endpackage

// File: rtl/cnt_ctrl_if.sv
// rtl/cnt_ctrl_if.sv - command handshake and run-result bundle between sequencer and cnt_ctrl
interface cnt_ctrl_if #(
  parameter int WIDTH  = cnt_pkg::CNT_WIDTH,
  parameter int TWIDTH = cnt_pkg::CNT_TWIDTH
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_load;
  logic              cmd_down;
  logic [TWIDTH-1:0] cmd_ticks;
  logic              done;
  logic [7:0]        hits;
  logic              err;

  modport master (
    output cmd_valid, cmd_load, cmd_down, cmd_ticks,
    input  cmd_ready, done, hits, err
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_down, cmd_ticks,
    output cmd_ready, done, hits, err
  );

endinterface

// File: rtl/cnt_ctrl_chk.sv
// rtl/cnt_ctrl_chk.sv - shadow prediction of the counter value and consistency compare
import cnt_pkg::*;

module cnt_ctrl_chk #(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic            clk,
  input  logic            rstn,
  input  cnt_ctrl_state_e state,
  input  logic [WIDTH-1:0] load_val,
  input  logic            down,
  input  logic [WIDTH-1:0] cnt_count,
  input  logic            cnt_rollover,
  output logic            mismatch
);

  logic [WIDTH-1:0] pred;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred <= '0;
    end else if (state == LOAD) begin
      pred <= load_val;
    end else if (state == RUN) begin
      pred <= down ? pred - 1'b1 : pred + 1'b1;
    end
  end

  // Rollover consistency is meaningful in every state; the value compare only once loaded.
  assign mismatch = (((state == RUN) || (state == DONE)) && (cnt_count != pred)) ||
                    (cnt_rollover != (&cnt_count));

endmodule

// File: rtl/cnt_ctrl.sv
// rtl/cnt_ctrl.sv - load/step/done sequencer for the up/down counter, all-ones hit counter
// Optional shadow checker built when CNT_CTRL_CHECK_EN is defined; otherwise err is constant 0.
import cnt_pkg::*;

module cnt_ctrl #(
  parameter int WIDTH  = CNT_WIDTH,
  parameter int TWIDTH = CNT_TWIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  cnt_ctrl_if.slave        cmd,
  output logic [WIDTH-1:0] cnt_load,
  output logic             cnt_load_en,
  output logic             cnt_down,
  input  logic [WIDTH-1:0] cnt_count,
  input  logic             cnt_rollover
);

  cnt_ctrl_state_e   state;
  logic [WIDTH-1:0]  load_q;
  logic              down_q;
  logic [TWIDTH-1:0] ticks_q;
  logic              done_q;
  logic [7:0]        hits_q;
  logic              err_q;
  logic              accept;

  assign accept = (state == IDLE) && cmd.cmd_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      load_q  <= '0;
      down_q  <= 1'b0;
      ticks_q <= '0;
      done_q  <= 1'b0;
      hits_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            load_q  <= cmd.cmd_load;
            down_q  <= cmd.cmd_down;
            ticks_q <= cmd.cmd_ticks;
            hits_q  <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (ticks_q != '0) begin
            state <= RUN;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        RUN: begin
          ticks_q <= ticks_q - 1'b1;
          if (ticks_q == TWIDTH'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (((state == RUN) || (state == DONE)) && cnt_rollover && (hits_q != 8'hFF)) begin
        hits_q <= hits_q + 8'd1;
      end
    end
  end

  // Outside LOAD and RUN the counter is frozen by reloading its own output.
  assign cnt_load_en = (state != RUN);
  assign cnt_load    = (state == LOAD) ? load_q : cnt_count;
  assign cnt_down    = (state == RUN) ? down_q : 1'b0;

`ifdef CNT_CTRL_CHECK_EN
  logic chk_mismatch;

  cnt_ctrl_chk #(.WIDTH(WIDTH)) u_chk (
    .clk          (clk),
    .rstn         (rstn),
    .state        (state),
    .load_val     (load_q),
    .down         (down_q),
    .cnt_count    (cnt_count),
    .cnt_rollover (cnt_rollover),
    .mismatch     (chk_mismatch)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (chk_mismatch) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err_q = 1'b0;
`endif

  assign cmd.cmd_ready = (state == IDLE);
  assign cmd.done      = done_q;
  assign cmd.hits      = hits_q;
  assign cmd.err       = err_q;

endmodule
